// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key tracker.
// Scan-code prefixes, default key codes, FSM and direction enums.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_e;

  typedef enum logic {
    LEFT,
    RIGHT
  } dir_e;

  localparam logic [7:0] BREAK_CODE    = 8'hF0;
  localparam logic [7:0] EXT_CODE      = 8'hE0;
  localparam logic [7:0] DEF_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] DEF_KEY_RIGHT = 8'h74;
  localparam logic [7:0] DEF_KEY_RESET = 8'h69;

endpackage

// File: rtl/ps2_seq_parser.sv
// PS/2 prefix parser: folds F0/E0 prefixes into complete codes.
// Flags malformed prefixes and prefix timeouts on seq_err.
module ps2_seq_parser
  import ps2_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ACCEPT_EXT = 1,
  parameter int TIMEOUT    = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              code_valid,
  output logic [DATA_W-1:0] code,
  output logic              is_break,
  output logic              seq_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] BRK_B = DATA_W'(BREAK_CODE);
  localparam logic [DATA_W-1:0] EXT_B = DATA_W'(EXT_CODE);
  localparam logic ACC = (ACCEPT_EXT != 0);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          is_f0, is_e0;

  assign is_f0 = (rx_data == BRK_B);
  assign is_e0 = (rx_data == EXT_B);

  // Next state, code strobe and idle-gap timer
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    err_d      = 1'b0;
    code_valid = 1'b0;
    is_break   = 1'b0;
    code       = rx_data;
    if (rx_valid) begin
      timer_d = '0;
      unique case (state_q)
        IDLE: begin
          if (is_f0)      state_d = BRK;
          else if (is_e0) state_d = EXT;
          else            code_valid = 1'b1;
        end
        EXT: begin
          if (is_f0) begin
            state_d = EXT_BRK;
          end else if (is_e0) begin
            err_d = 1'b1;
          end else begin
            code_valid = ACC;
            state_d    = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          state_d = IDLE;
          if (is_f0 || is_e0) begin
            err_d = 1'b1;
          end else begin
            code_valid = (state_q == BRK) || ACC;
            is_break   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (timer_q == T_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // State, timer and error pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign seq_err = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks held state of left/right/reset keys from PS/2 codes.
// Drives priority-resolved paddle levels and a stretched reset.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter logic [DATA_W-1:0] KEY_LEFT  = DATA_W'(DEF_KEY_LEFT),
  parameter logic [DATA_W-1:0] KEY_RIGHT = DATA_W'(DEF_KEY_RIGHT),
  parameter logic [DATA_W-1:0] KEY_RESET = DATA_W'(DEF_KEY_RESET),
  parameter int ACCEPT_EXT  = 1,
  parameter int RESET_PULSE = 4,
  parameter int TIMEOUT     = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              right,
  output logic              left,
  output logic              game_reset,
  output logic              seq_err
);

  localparam int PW = $clog2(RESET_PULSE + 1);
  localparam logic [PW-1:0] P_LOAD = PW'(RESET_PULSE);

  logic              code_valid;
  logic [DATA_W-1:0] code;
  logic              is_break;

  ps2_seq_parser #(
    .DATA_W    (DATA_W),
    .ACCEPT_EXT(ACCEPT_EXT),
    .TIMEOUT   (TIMEOUT)
  ) u_parser (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .code_valid(code_valid),
    .code      (code),
    .is_break  (is_break),
    .seq_err   (seq_err)
  );

  logic          lh_q, lh_d;
  logic          rh_q, rh_d;
  logic          rsh_q, rsh_d;
  dir_e          last_q, last_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          left_q, left_d;
  logic          right_q, right_d;

  // Held flags, last direction, reset stretch and paddle priority
  always_comb begin
    lh_d    = lh_q;
    rh_d    = rh_q;
    rsh_d   = rsh_q;
    last_d  = last_q;
    pulse_d = (pulse_q != '0) ? pulse_q - 1'b1 : '0;
    if (code_valid) begin
      unique case (1'b1)
        (code == KEY_LEFT): begin
          if (is_break) begin
            lh_d = 1'b0;
          end else begin
            lh_d   = 1'b1;
            last_d = LEFT;
          end
        end
        (code == KEY_RIGHT): begin
          if (is_break) begin
            rh_d = 1'b0;
          end else begin
            rh_d   = 1'b1;
            last_d = RIGHT;
          end
        end
        (code == KEY_RESET): begin
          if (is_break) begin
            rsh_d = 1'b0;
          end else if (!rsh_q) begin
            rsh_d   = 1'b1;
            pulse_d = P_LOAD;
            lh_d    = 1'b0;
            rh_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
    left_d  = lh_d & (~rh_d | (last_d == LEFT));
    right_d = rh_d & (~lh_d | (last_d == RIGHT));
  end

  // Key state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lh_q    <= 1'b0;
      rh_q    <= 1'b0;
      rsh_q   <= 1'b0;
      last_q  <= LEFT;
      pulse_q <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      lh_q    <= lh_d;
      rh_q    <= rh_d;
      rsh_q   <= rsh_d;
      last_q  <= last_d;
      pulse_q <= pulse_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign left       = left_q;
  assign right      = right_q;
  assign game_reset = (pulse_q != '0);

endmodule
